// File: rtl/round_ctrl.sv
// AES-128 encryption round controller: iterates one round per accepted round key
// over a 128-bit state register. Define ROUND_CTRL_ABORT_EN to add the abort input.

module sub_bytes (
   input  logic [127:0] din,
   output logic [127:0] dout
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [10:0] base;
      base = 11'd2047 - {a, 3'b000};
      return SBOX[base -: 8];
   endfunction

   for (genvar i = 0; i < 16; i++) begin : g_byte
      assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
   end
endmodule

module shift_rows (
   input  logic [127:0] din,
   output logic [127:0] dout
);
   // Byte 4*c+r sits at bits [127-8*(4c+r) -: 8]; row r rotates left by r columns.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign dout[127-8*(4*c+r) -: 8] = din[127-8*(4*((c+r)%4)+r) -: 8];
      end
   end
endmodule

module mix_col (
   input  logic [127:0] din,
   output logic [127:0] dout
);
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = din[127-32*c -: 8];
      assign a1 = din[119-32*c -: 8];
      assign a2 = din[111-32*c -: 8];
      assign a3 = din[103-32*c -: 8];
      assign dout[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      assign dout[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      assign dout[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      assign dout[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
   end
endmodule

module round_ctrl (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         start,
`ifdef ROUND_CTRL_ABORT_EN
   input  logic         abort,
`endif
   input  logic [127:0] data_in,
   input  logic [127:0] round_key,
   input  logic         key_valid,
   output logic         key_req,
   output logic [3:0]   round_num,
   output logic [127:0] data_out,
   output logic         busy,
   output logic         done
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] INIT  = 3'd1;
   localparam logic [2:0] ROUND = 3'd2;
   localparam logic [2:0] FINAL = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   logic [2:0]   fsm_q, fsm_d;
   logic [127:0] blk_q, blk_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [127:0] dout_q, dout_d;
   logic [127:0] sb_out, sr_out, mc_out;

   sub_bytes  u_sub_bytes  (.din(blk_q),  .dout(sb_out));
   shift_rows u_shift_rows (.din(sb_out), .dout(sr_out));
   mix_col    u_mix_col    (.din(sr_out), .dout(mc_out));

   assign key_req   = (fsm_q == INIT) || (fsm_q == ROUND) || (fsm_q == FINAL);
   assign busy      = (fsm_q != IDLE);
   assign done      = (fsm_q == DONE);
   assign round_num = rnd_q;
   assign data_out  = dout_q;

   always_comb begin
      fsm_d  = fsm_q;
      blk_d  = blk_q;
      rnd_d  = rnd_q;
      dout_d = dout_q;
      case (fsm_q)
         IDLE: if (start) begin
            blk_d = data_in;
            rnd_d = 4'd0;
            fsm_d = INIT;
         end
         INIT: if (key_valid) begin
            blk_d = blk_q ^ round_key;
            rnd_d = 4'd1;
            fsm_d = ROUND;
         end
         ROUND: if (key_valid) begin
            blk_d = mc_out ^ round_key;
            rnd_d = rnd_q + 4'd1;
            if (rnd_q == 4'd9) fsm_d = FINAL;
         end
         FINAL: if (key_valid) begin
            dout_d = sr_out ^ round_key;
            fsm_d  = DONE;
         end
         DONE:    fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
`ifdef ROUND_CTRL_ABORT_EN
      // Abort wins over a same-cycle key and leaves the last ciphertext intact.
      if (abort && key_req) begin
         fsm_d  = IDLE;
         rnd_d  = 4'd0;
         blk_d  = blk_q;
         dout_d = dout_q;
      end
`endif
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         fsm_q  <= IDLE;
         blk_q  <= '0;
         rnd_q  <= '0;
         dout_q <= '0;
      end else begin
         fsm_q  <= fsm_d;
         blk_q  <= blk_d;
         rnd_q  <= rnd_d;
         dout_q <= dout_d;
      end
   end
endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl: AES-128 reference built from GF(2^8) arithmetic, known
// vectors, stalls, ignored restarts, mid-run reset and (with ROUND_CTRL_ABORT_EN) abort.

module tb_round_ctrl;
   logic         clk = 1'b0;
   logic         n_rst, start, key_valid, key_req, busy, done;
   logic [127:0] data_in, round_key, data_out;
   logic [3:0]   round_num;
`ifdef ROUND_CTRL_ABORT_EN
   logic         abort;
`endif

   int checks = 0;
   int errors = 0;
   logic [7:0]   sbox_t[256];
   logic [127:0] rk[11];
   logic [127:0] exp_q[$];

   localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   always #5 clk = ~clk;

   round_ctrl dut (
      .clk(clk), .n_rst(n_rst), .start(start),
`ifdef ROUND_CTRL_ABORT_EN
      .abort(abort),
`endif
      .data_in(data_in), .round_key(round_key), .key_valid(key_valid),
      .key_req(key_req), .round_num(round_num), .data_out(data_out),
      .busy(busy), .done(done));

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int a = 0; a < 256; a++) begin
         inv = 8'h00;
         if (a != 0)
            for (int b = 1; b < 256; b++)
               if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         sbox_t[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                     {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   task automatic expand(input logic [127:0] key);
      logic [31:0] w[44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
            t[31:24] = t[31:24] ^ rc;
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] pt);
      logic [7:0]   s[16];
      logic [7:0]   t[16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] ct;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = s[4*((c+r)%4)+r];
         if (rnd < 10)
            for (int c = 0; c < 4; c++) begin
               a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
               t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         for (int i = 0; i < 16; i++) s[i] = t[i] ^ rk[rnd][127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
      return ct;
   endfunction

   // ---------------- driver ----------------
   function automatic logic [127:0] key_for(input logic [3:0] rn);
      return (rn <= 4'd10) ? rk[rn] : 128'h0;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Starts one block and serves keys; cycle 1 is the cycle after the start-sampling edge.
   task automatic drive_block(input logic [127:0] pt, input logic [127:0] key,
                              input int stall_at, input int stall_len, input int restart_at,
                              output int done_cyc, output int done_cnt, output int hold_cnt,
                              output int early_chg, output logic [127:0] ct);
      logic [127:0] prev_out;
      int stalled, tail;
      expand(key);
      done_cyc = -1; done_cnt = 0; hold_cnt = 0; early_chg = 0;
      stalled = 0; tail = 0; ct = '0;
      @(negedge clk);
      data_in = pt; start = 1'b1; key_valid = 1'b1; prev_out = data_out;
      @(posedge clk);
      for (int cyc = 1; cyc <= 60 && tail < 4; cyc++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) begin done_cyc = cyc; ct = data_out; end
         end
         if (done_cyc < 0 && data_out !== prev_out) early_chg++;
         if (done_cyc >= 0) tail++;
         if (stall_at >= 0 && int'(round_num) == stall_at && key_req) hold_cnt++;
         data_in   = rand128();
         round_key = key_for(round_num);
         key_valid = 1'b1;
         if (!key_req) begin
            key_valid = 1'($urandom_range(0, 1));
            round_key = rand128();
         end
         if (stall_at >= 0 && int'(round_num) == stall_at && key_req && stalled < stall_len) begin
            key_valid = 1'b0;
            stalled++;
         end
         start = (restart_at >= 0 && int'(round_num) == restart_at && key_req);
      end
      start = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      n_rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (key_req !== 1'b0)  begin errors++; $display("FAIL reset_key_req: got %b expected 0", key_req); end
      checks++; if (round_num !== 4'd0) begin errors++; $display("FAIL reset_round_num: got %0d expected 0", round_num); end
      checks++; if (data_out !== 128'h0) begin errors++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0 || key_req !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset: got busy=%b key_req=%b expected 0/0", busy, key_req);
      end
   endtask

   task automatic test_vector(input string name, input logic [127:0] pt, input logic [127:0] key,
                              input logic [127:0] golden);
      int dc, dn, hc, ec;
      logic [127:0] ct;
      logic [127:0] model;
      drive_block(pt, key, -1, 0, -1, dc, dn, hc, ec, ct);
      model = aes_enc(pt);
      checks++; if (ct !== golden) begin errors++; $display("FAIL %s_golden: got %h expected %h", name, ct, golden); end
      checks++; if (ct !== model)  begin errors++; $display("FAIL %s_model: got %h expected %h", name, ct, model); end
      checks++; if (dc != 12) begin errors++; $display("FAIL %s_latency: got %0d expected 12", name, dc); end
      checks++; if (dn != 1)  begin errors++; $display("FAIL %s_done_count: got %0d expected 1", name, dn); end
      checks++; if (ec != 0)  begin errors++; $display("FAIL %s_early_change: got %0d expected 0", name, ec); end
      checks++; if (data_out !== golden) begin errors++; $display("FAIL %s_hold: got %h expected %h", name, data_out, golden); end
      checks++; if (round_num !== 4'd10) begin errors++; $display("FAIL %s_round_num_idle: got %0d expected 10", name, round_num); end
   endtask

   task automatic test_stall();
      int dc, dn, hc, ec;
      logic [127:0] ct;
      drive_block(B_PT, B_KEY, 5, 3, -1, dc, dn, hc, ec, ct);
      checks++; if (ct !== B_CT) begin errors++; $display("FAIL stall_ct: got %h expected %h", ct, B_CT); end
      checks++; if (dc != 15) begin errors++; $display("FAIL stall_latency: got %0d expected 15", dc); end
      checks++; if (hc != 4)  begin errors++; $display("FAIL stall_hold_rn5_keyreq: got %0d cycles expected 4", hc); end
      checks++; if (dn != 1)  begin errors++; $display("FAIL stall_done_count: got %0d expected 1", dn); end
   endtask

   task automatic test_restart();
      int dc, dn, hc, ec;
      logic [127:0] ct;
      drive_block(C_PT, C_KEY, -1, 0, 4, dc, dn, hc, ec, ct);
      checks++; if (ct !== C_CT) begin errors++; $display("FAIL restart_ct: got %h expected %h", ct, C_CT); end
      checks++; if (dn != 1)  begin errors++; $display("FAIL restart_done_count: got %0d expected 1", dn); end
      checks++; if (dc != 12) begin errors++; $display("FAIL restart_latency: got %0d expected 12", dc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_no_queue: got busy=%b expected 0", busy); end
   endtask

   task automatic test_random();
      int dc, dn, hc, ec, sa, sl;
      logic [127:0] ct, pt, key, exp_ct;
      for (int n = 0; n < 8; n++) begin
         pt  = rand128();
         key = rand128();
         sa  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 9));
         sl  = (sa < 0) ? 0 : int'($urandom_range(0, 4));
         expand(key);
         exp_q.push_back(aes_enc(pt));
         drive_block(pt, key, sa, sl, -1, dc, dn, hc, ec, ct);
         exp_ct = exp_q.pop_front();
         checks++; if (ct !== exp_ct) begin errors++; $display("FAIL random_ct[%0d]: got %h expected %h", n, ct, exp_ct); end
         checks++; if (dc != 12 + sl) begin errors++; $display("FAIL random_latency[%0d]: got %0d expected %0d", n, dc, 12 + sl); end
         checks++; if (ec != 0 || dn != 1) begin
            errors++; $display("FAIL random_done[%0d]: got count=%0d early=%0d expected 1/0", n, dn, ec);
         end
      end
   endtask

   task automatic test_reset_mid();
      int dc, dn, hc, ec, guard;
      logic [127:0] ct;
      expand(B_KEY);
      @(negedge clk);
      data_in = B_PT; start = 1'b1; key_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (round_num != 4'd7 && guard < 30) begin
         round_key = key_for(round_num);
         @(negedge clk);
         guard++;
      end
      checks++; if (round_num !== 4'd7) begin errors++; $display("FAIL midreset_reach_rn7: got %0d expected 7", round_num); end
      n_rst = 1'b0;
      #1;
      checks++; if ({busy, done, key_req} !== 3'b000) begin
         errors++; $display("FAIL midreset_flags: got %b expected 000", {busy, done, key_req});
      end
      checks++; if (round_num !== 4'd0) begin errors++; $display("FAIL midreset_round_num: got %0d expected 0", round_num); end
      checks++; if (data_out !== 128'h0) begin errors++; $display("FAIL midreset_data_out: got %h expected 0", data_out); end
      @(negedge clk);
      n_rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_waits: got busy=%b expected 0", busy); end
      drive_block(C_PT, C_KEY, -1, 0, -1, dc, dn, hc, ec, ct);
      checks++; if (ct !== C_CT) begin errors++; $display("FAIL midreset_next_ct: got %h expected %h", ct, C_CT); end
      checks++; if (dc != 12) begin errors++; $display("FAIL midreset_next_latency: got %0d expected 12", dc); end
   endtask

`ifdef ROUND_CTRL_ABORT_EN
   task automatic test_abort();
      int guard, dn;
      expand(C_KEY);
      @(negedge clk);
      data_in = C_PT; start = 1'b1; key_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (round_num != 4'd3 && guard < 30) begin
         round_key = key_for(round_num);
         @(negedge clk);
         guard++;
      end
      abort = 1'b1; round_key = key_for(round_num);
      @(negedge clk);
      abort = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      checks++; if (round_num !== 4'd0) begin errors++; $display("FAIL abort_round_num: got %0d expected 0", round_num); end
      checks++; if (data_out !== C_CT) begin errors++; $display("FAIL abort_data_out: got %h expected %h", data_out, C_CT); end
      dn = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) dn++;
         @(negedge clk);
      end
      checks++; if (dn != 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", dn); end
   endtask
`endif

   initial begin
      n_rst = 1'b0; start = 1'b0; key_valid = 1'b0;
      data_in = '0; round_key = '0;
`ifdef ROUND_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      build_sbox();
      test_reset();
      test_vector("fips_b", B_PT, B_KEY, B_CT);
      test_vector("fips_c1", C_PT, C_KEY, C_CT);
      test_stall();
      test_restart();
      test_random();
      test_reset_mid();
`ifdef ROUND_CTRL_ABORT_EN
      test_abort();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-low reset; clock and reset ports SHALL be named clk and n_rst.
REQ-002 The ports SHALL be, clock and reset first:
- clk  input  1  rising-edge clock
- n_rst  input  1  asynchronous active-low reset
- start  input  1  begin encryption of data_in; sampled only in IDLE
- data_in  input  128  plaintext block
- round_key  input  128  round key for round_num
- key_valid  input  1  round_key valid this cycle
- key_req  output  1  round key wanted for round_num
- round_num  output  4  round index 0..10
- data_out  output  128  ciphertext register
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when data_out is updated
REQ-003 The block SHALL instantiate the existing combinational 128-bit sub_bytes, shift_rows and mix_col blocks on an internal 128-bit state register; no other datapath duplication is permitted.

Function
REQ-004 The FSM SHALL have states IDLE, INIT, ROUND, FINAL and DONE.
REQ-005 IDLE: when start=1, the block SHALL load state<=data_in, set round_num<=0 and go to INIT; otherwise it SHALL stay in IDLE.
REQ-006 INIT: key_req=1; when key_valid=1, the block SHALL set state<=state^round_key, round_num<=1 and go to ROUND.
REQ-007 ROUND: key_req=1; when key_valid=1, the block SHALL set state<=mix_col(shift_rows(sub_bytes(state)))^round_key and round_num<=round_num+1; it SHALL go to FINAL if round_num was 9, else it SHALL stay in ROUND.
REQ-008 FINAL (round_num=10): key_req=1; when key_valid=1, the block SHALL set data_out<=shift_rows(sub_bytes(state))^round_key and go to DONE; mix_col SHALL NOT be applied in this round.
REQ-009 DONE: done=1, key_req=0; the block SHALL go to IDLE unconditionally, and start SHALL be ignored in this state.
REQ-010 key_valid=0 in INIT, ROUND or FINAL SHALL stall: the state register, round_num and FSM state SHALL hold, and key_req SHALL stay high.
REQ-011 key_req SHALL be 0 in IDLE and DONE; round_key and key_valid SHALL be ignored there.
REQ-012 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-013 With key_valid held at 1, done SHALL assert exactly 12 cycles after the edge that samples start.
REQ-014 data_out SHALL change only on the FINAL-to-DONE transition (or on reset/abort) and SHALL otherwise hold its value across subsequent operations until the next completion.
REQ-015 round_num SHALL never exceed 10 and SHALL never wrap.
REQ-016 In IDLE and DONE, round_num SHALL hold its last value.

Reset
REQ-017 When n_rst=0, the block SHALL asynchronously force state IDLE, state register 0, data_out 0, round_num 0, busy 0, done 0 and key_req 0.
REQ-018 Reset asserted mid-operation SHALL discard the block in progress; after release the block SHALL wait for a new start.

Configuration
REQ-019 With macro ROUND_CTRL_ABORT_EN defined, the block SHALL have an extra input port abort (1 bit) placed after start.
REQ-020 With ROUND_CTRL_ABORT_EN defined, abort=1 in INIT, ROUND or FINAL SHALL force IDLE on the next edge, with round_num 0, done not asserted and data_out unchanged.
REQ-021 With ROUND_CTRL_ABORT_EN defined, abort SHALL take priority over key_valid and SHALL be ignored in IDLE and DONE.
REQ-022 Without ROUND_CTRL_ABORT_EN, the abort port SHALL be absent and there SHALL be no abort logic.

Verification
REQ-023 The bench SHALL cover FIPS-197 App. B: data_in=3243f6a8885a308d313198a2e0370734 with expanded keys of 2b7e151628aed2a6abf7158809cf4f3c and key_valid=1 -> data_out=3925841d02dc09fbdc118597196a0b32 and done 12 cycles after start.
REQ-024 The bench SHALL cover FIPS-197 App. C.1: data_in=00112233445566778899aabbccddeeff with key 000102030405060708090a0b0c0d0e0f -> data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-025 The bench SHALL cover stalls: the App. B vector with key_valid low for 3 cycles at round_num=5 -> round_num holds at 5 with key_req=1, the same ciphertext, and done at cycle 15.
REQ-026 The bench SHALL cover start re-asserted at round_num=4 -> ignored, the first result is unaffected, and done pulses exactly once.
REQ-027 The bench SHALL cover n_rst dropped at round_num=7 -> all outputs 0 immediately; then a new start with the App. C.1 vector -> the correct ciphertext.
REQ-028 The bench SHALL cover the abort build (ROUND_CTRL_ABORT_EN): abort=1 at round_num=3 -> IDLE on the next cycle, busy=0, no done, and data_out keeps the previous ciphertext.
